// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its two-client arbiter: opcodes, flag
// bit positions and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_AND    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_INC    = 4'b0101;
  localparam logic [3:0] OP_PASS_A = 4'b0110;

  // Bit positions inside the 3-bit {overflow, negative, zero} flag vector.
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie
// the requester that did not win last time is picked.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  assign grant_valid = |valid;

  always_comb begin
    grant_id = 1'b0;
    if (valid == 2'b11) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and returns
// each result on a single tagged response channel.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits for ready, ready may depend on valid.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [BW-1:0] req0_a,
  input  logic [BW-1:0] req0_b,
  input  logic [3:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [BW-1:0] req1_a,
  input  logic [BW-1:0] req1_b,
  input  logic [3:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [BW-1:0] rsp_out,
  output logic [2:0]    rsp_flags,
  output logic [BW-1:0] alu_a,
  output logic [BW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [BW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic [1:0]    dbg_state
);

  arb_state_e state_q, state_d;
  logic       last_grant_q;
  logic       grant_valid;
  logic       grant_id;
  logic       accept;

  rr_arbiter_2 u_rr (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_out      <= '0;
      rsp_flags    <= '0;
    end else begin
      state_q <= state_d;
      // ALU operand registers only move on an accepted request.
      if (accept) begin
        alu_a        <= grant_id ? req1_a  : req0_a;
        alu_b        <= grant_id ? req1_b  : req0_b;
        alu_op       <= grant_id ? req1_op : req0_op;
        rsp_id       <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_out   <= alu_out;
        rsp_flags <= alu_flags;
        rsp_valid <= 1'b1;
      end
      if ((state_q == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run checked
// against an integer-arithmetic reference and an expected-response queue.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int BW = 16;
  localparam int W  = BW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [BW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic          rsp_valid, rsp_id;
  logic          rsp_ready = 1'b0;
  logic [BW-1:0] rsp_out;
  logic [2:0]    rsp_flags;
  logic [BW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_op;
  logic [2:0]    alu_flags;
  logic [1:0]    dbg_state;

  int n_run  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  alu_arbiter #(.BW(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Stand-in for the attached combinational ALU (bit-level).
  logic          alu_ovf;
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_out = alu_a + alu_b;
        alu_ovf = (alu_a[BW-1] == alu_b[BW-1]) && (alu_out[BW-1] != alu_a[BW-1]);
      end
      OP_SUB: begin
        alu_out = alu_a - alu_b;
        alu_ovf = (alu_a[BW-1] != alu_b[BW-1]) && (alu_out[BW-1] != alu_a[BW-1]);
      end
      OP_AND:    alu_out = alu_a & alu_b;
      OP_OR:     alu_out = alu_a | alu_b;
      OP_XOR:    alu_out = alu_a ^ alu_b;
      OP_INC: begin
        alu_out = alu_a + 16'd1;
        alu_ovf = (alu_a == 16'h7fff);
      end
      OP_PASS_A: alu_out = alu_a;
      default:   alu_out = alu_b;
    endcase
    alu_flags = {alu_ovf, alu_out[BW-1], (alu_out == '0)};
  end

  // Reference: signed integer arithmetic, then range check for overflow.
  function automatic logic [W-1:0] ref_rsp(input logic id, input logic [BW-1:0] a,
                                           input logic [BW-1:0] b, input logic [3:0] op);
    int sa, sb, r;
    logic [BW-1:0] o;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0:    r = sa + sb;
      4'd1:    r = sa - sb;
      4'd2:    r = sa & sb;
      4'd3:    r = sa | sb;
      4'd4:    r = sa ^ sb;
      4'd5:    r = sa + 1;
      4'd6:    r = sa;
      default: r = sb;
    endcase
    ovf = (op == 4'd0 || op == 4'd1 || op == 4'd5) && (r > 32767 || r < -32768);
    o = r[BW-1:0];
    return {id, ovf, o[BW-1], (o == 0), o};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_flags} !== '0) begin
      n_fail++; $display("FAIL reset_rsp: got v=%0b id=%0b out=%0h fl=%b, want all 0", rsp_valid, rsp_id, rsp_out, rsp_flags);
    end
    n_run++;
    if ({alu_a, alu_b, alu_op} !== '0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_alu: got a=%0h b=%0h op=%0h st=%0d, want 0", alu_a, alu_b, alu_op, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_tie: got r0=%0b r1=%0b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single(input logic id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                             input logic [3:0] op, input logic [BW-1:0] eout, input logic [2:0] efl);
    do_reset();
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    n_run++;
    if (req0_ready !== !id || req1_ready !== id) begin
      n_fail++; $display("FAIL single%0d_ready: got r0=%0b r1=%0b", id, req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    n_run++;
    if (rsp_valid !== 1'b0 || alu_a !== a || alu_b !== b || alu_op !== op) begin
      n_fail++; $display("FAIL single%0d_exec: got v=%0b a=%0h b=%0h op=%0h", id, rsp_valid, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    #1;
    n_run++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_flags} !== {1'b1, id, eout, efl}) begin
      n_fail++; $display("FAIL single%0d_rsp: got v=%0b id=%0b out=%0d fl=%b, want id=%0b out=%0d fl=%b",
                         id, rsp_valid, rsp_id, $signed(rsp_out), rsp_flags, id, $signed(eout), efl);
    end
    @(negedge clk);
    #1;
    n_run++;
    if (rsp_valid !== 1'b0 || rsp_out !== eout || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL single%0d_after: got v=%0b out=%0d st=%0d", id, rsp_valid, $signed(rsp_out), dbg_state);
    end
  endtask

  task automatic test_fairness();
    int nrsp = 0;
    int ngrant = 0;
    logic prev_g = 1'b0;
    logic [BW-1:0] eo;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'd30000; req0_b = 16'd10000; req0_op = OP_SUB;
    req1_valid = 1'b1; req1_a = 16'd15;    req1_b = 16'd27;    req1_op = OP_AND;
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        n_run++;
        if ((req0_ready && req1_ready) || (ngrant > 0 && req1_ready == prev_g)) begin
          n_fail++; $display("FAIL fair_grant: got r0=%0b r1=%0b prev=%0b", req0_ready, req1_ready, prev_g);
        end
        prev_g = req1_ready;
        ngrant++;
      end
      if (rsp_valid) begin
        eo = (nrsp % 2 == 0) ? 16'd20000 : 16'd11;
        n_run++;
        if (rsp_id !== nrsp[0] || rsp_out !== eo || rsp_flags !== 3'b000) begin
          n_fail++; $display("FAIL fair_rsp%0d: got id=%0b out=%0d fl=%b, want id=%0b out=%0d fl=000",
                             nrsp, rsp_id, rsp_out, rsp_flags, nrsp[0], eo);
        end
        nrsp++;
        if (nrsp == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_run++;
    if (nrsp != 4) begin
      n_fail++; $display("FAIL fair_timeout: got %0d responses, want 4", nrsp);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd29; req0_b = 16'd15; req0_op = OP_XOR;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      n_run++;
      if (rsp_valid !== 1'b1 || rsp_out !== 16'd18 || req0_ready || req1_ready || dbg_state !== 2'd2) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%0b out=%0d r0=%0b r1=%0b st=%0d, want v=1 out=18 r=0 st=2",
                           i, rsp_valid, rsp_out, req0_ready, req1_ready, dbg_state);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_run++;
    if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || rsp_out !== 16'd18) begin
      n_fail++; $display("FAIL bp_release: got v=%0b st=%0d out=%0d, want v=0 st=0 out=18", rsp_valid, dbg_state, rsp_out);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_a = 16'd42; req1_b = 16'd0; req1_op = OP_INC;
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (rsp_valid !== 1'b0 || alu_a !== '0 || alu_op !== '0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_exec: got v=%0b a=%0d op=%0d st=%0d, want 0", rsp_valid, alu_a, alu_op, dbg_state);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_exec_norsp%0d: got rsp_valid=%0b, want 0", i, rsp_valid);
      end
    end
    req0_valid = 1'b1; req0_a = 16'd7; req0_b = 16'd3; req0_op = OP_PASS_A;
    req1_valid = 1'b1;
    #1;
    n_run++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_exec_tie: got r0=%0b r1=%0b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    n_run++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 16'd7) begin
      n_fail++; $display("FAIL rst_exec_next: got v=%0b id=%0b out=%0d, want v=1 id=0 out=7", rsp_valid, rsp_id, rsp_out);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_in_resp();
    do_reset();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd10; req1_op = OP_OR;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1; req0_op = OP_ADD;
    #1;
    n_run++;
    if (req0_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_out !== 16'd15) begin
      n_fail++; $display("FAIL drop_resp: got r0=%0b v=%0b out=%0d, want r0=0 v=1 out=15", req0_ready, rsp_valid, rsp_out);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      n_run++;
      if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
        n_fail++; $display("FAIL drop_norsp%0d: got v=%0b st=%0d, want v=0 st=0", i, rsp_valid, dbg_state);
      end
    end
  endtask

  task automatic test_random();
    logic last_g = 1'b1;
    logic busy = 1'b0;
    logic eid;
    logic [W-1:0] got;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 4'($urandom_range(0, 15));
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req0_a = 16'h7fff;
      rsp_ready = ($urandom_range(0, 2) != 0) || (cyc >= 580);
      if (cyc >= 580) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      n_run++;
      if (!busy && (req0_valid || req1_valid)) begin
        eid = (req0_valid && req1_valid) ? ~last_g : req1_valid;
        if (req0_ready !== !eid || req1_ready !== eid) begin
          n_fail++; $display("FAIL rnd_grant c%0d: got r0=%0b r1=%0b, want id %0b", cyc, req0_ready, req1_ready, eid);
        end
        exp_q.push_back(eid ? ref_rsp(1'b1, req1_a, req1_b, req1_op) : ref_rsp(1'b0, req0_a, req0_b, req0_op));
        last_g = eid;
        busy = 1'b1;
      end else if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got r0=%0b r1=%0b busy=%0b, want 0", cyc, req0_ready, req1_ready, busy);
      end
      if (rsp_valid) begin
        n_run++;
        got = {rsp_id, rsp_flags, rsp_out};
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_rsp c%0d: got %h, want no response", cyc, got);
        end else begin
          if (got !== exp_q[0]) begin
            n_fail++; $display("FAIL rnd_rsp c%0d: got %h, want %h", cyc, got, exp_q[0]);
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
      @(negedge clk);
    end
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d outstanding, want 0", exp_q.size());
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 16'd10000, 16'd20000, OP_ADD, 16'd30000, 3'b000);
    test_single(1'b1, 16'd30000, 16'd10000, OP_ADD, 16'h9c40, 3'b110);
    test_fairness();
    test_back_pressure();
    test_reset_exec();
    test_drop_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
